// File: rtl/int_sched_pkg.sv
// Shared types and helpers for the int_sched interrupt scheduler.
// Priority arithmetic is done modulo the configured source count.
package int_sched_pkg;

  localparam int NSRC_MAX = 7;
  localparam logic [2:0] SPUR_IDX = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ASSERT = 3'd1,
    INTA1  = 3'd2,
    GAP    = 3'd3,
    INTA2  = 3'd4
  } state_e;

  function automatic logic [2:0] wrap_add(logic [2:0] a, logic [2:0] b, int nsrc);
    int s;
    s = int'(a) + int'(b);
    if (s >= nsrc) s = s - nsrc;
    return 3'(s);
  endfunction

  function automatic logic [2:0] next_ptr(logic [2:0] n, int nsrc);
    return wrap_add(n, 3'd1, nsrc);
  endfunction

  // Distance from the priority pointer: 0 is the highest priority.
  function automatic logic [2:0] prio_rank(logic [2:0] idx, logic [2:0] ptr, int nsrc);
    int r;
    r = int'(idx) - int'(ptr);
    if (r < 0) r = r + nsrc;
    return 3'(r);
  endfunction

endpackage

// File: rtl/int_sched_if.sv
// Request, register-write, acknowledge and vector signals of int_sched.
// The CPU/system side uses master, the scheduler uses slave.
interface int_sched_if #(parameter int NSRC = 4);

  logic [NSRC-1:0] REQ;
  logic [7:0]      WD;
  logic            MASKW;
  logic            MODEW;
  logic            INTAL;
  logic            ACK;
  logic            INTL;
  logic [7:0]      VEC;
  logic            VOE;
  logic [NSRC-1:0] PEND;
  logic [NSRC-1:0] INSV;

  modport master (
    output REQ, WD, MASKW, MODEW, INTAL, ACK,
    input  INTL, VEC, VOE, PEND, INSV
  );

  modport slave (
    input  REQ, WD, MASKW, MODEW, INTAL, ACK,
    output INTL, VEC, VOE, PEND, INSV
  );

endinterface

// File: rtl/int_prio_enc.sv
// Rotating-priority encoder: finds the first set bit of vec scanning
// ptr, ptr+1, ... NSRC-1, 0, ... ptr-1.
module int_prio_enc
  import int_sched_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] vec,
  input  logic [2:0]      ptr,
  output logic            valid,
  output logic [2:0]      idx
);

  logic [2*NSRC-1:0] dbl;
  logic [NSRC-1:0]   rot_vec;
  logic [2:0]        offset;

  // Bit k of rot_vec is source (ptr + k) mod NSRC.
  assign dbl     = {vec, vec} >> ptr;
  assign rot_vec = dbl[NSRC-1:0];

  always_comb begin
    valid  = 1'b0;
    offset = 3'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (rot_vec[k]) begin
        valid  = 1'b1;
        offset = 3'(k);
      end
    end
  end

  assign idx = wrap_add(ptr, offset, NSRC);

endmodule

// File: rtl/int_sched.sv
// Programmable interrupt scheduler: edge-latched requests, masking,
// fixed/rotating priority with nesting, and a two-pulse INTA vector handshake.
module int_sched
  import int_sched_pkg::*;
#(
  parameter int NSRC = 4
) (
  input logic        CLK,
  input logic        RESETL_0,
  int_sched_if.slave bus
);

  localparam logic [2:0]      ST_IDLE   = IDLE;
  localparam logic [2:0]      ST_ASSERT = ASSERT;
  localparam logic [2:0]      ST_INTA1  = INTA1;
  localparam logic [2:0]      ST_GAP    = GAP;
  localparam logic [2:0]      ST_INTA2  = INTA2;
  localparam logic [NSRC-1:0] ONE       = NSRC'(1);

  logic [NSRC-1:0] req_reg, pend_reg, mask_reg, insv_reg;
  logic            rotate_reg;
  logic [4:0]      base_reg;
  logic [2:0]      ptr_reg;
  logic [2:0]      state_reg, state_next;
  logic [2:0]      win_reg, win_next;
  logic            intal_reg, intl_reg, voe_reg;
  logic [7:0]      vec_reg;

  logic [NSRC-1:0] req_rise, elig, pend_clr, insv_set, insv_clr;
  logic            win_valid, insv_valid, eoi, vec_load;
  logic [2:0]      win_idx, insv_idx, insv_rank;
  logic            unused_wd;

  assign unused_wd = ^bus.WD;
  assign req_rise  = bus.REQ & ~req_reg;

  int_prio_enc #(.NSRC(NSRC)) u_win_enc (
    .vec   (elig),
    .ptr   (ptr_reg),
    .valid (win_valid),
    .idx   (win_idx)
  );

  int_prio_enc #(.NSRC(NSRC)) u_insv_enc (
    .vec   (insv_reg),
    .ptr   (ptr_reg),
    .valid (insv_valid),
    .idx   (insv_idx)
  );

  assign insv_rank = prio_rank(insv_idx, ptr_reg, NSRC);

  // Only strictly higher priority than the top in-service level may nest.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_elig
    logic [2:0] rank;
    assign rank     = prio_rank(3'(gi), ptr_reg, NSRC);
    assign elig[gi] = pend_reg[gi] & ~mask_reg[gi] & (~insv_valid | (rank < insv_rank));
  end

  assign eoi      = bus.ACK & insv_valid;
  assign insv_clr = eoi ? (ONE << insv_idx) : '0;

  // intal_reg is the single-register view of the pin, so levels per state act as edges.
  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    pend_clr   = '0;
    insv_set   = '0;
    vec_load   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_valid) state_next = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (!intal_reg) begin
          state_next = ST_INTA1;
          vec_load   = 1'b1;
          if (win_valid) begin
            win_next = win_idx;
            pend_clr = ONE << win_idx;
          end else begin
            win_next = SPUR_IDX;
          end
        end else if (!win_valid) begin
          state_next = ST_IDLE;
        end
      end
      ST_INTA1: begin
        if (intal_reg) state_next = ST_GAP;
      end
      ST_GAP: begin
        if (!intal_reg) begin
          state_next = ST_INTA2;
          if (win_reg != SPUR_IDX) insv_set = ONE << win_reg;
        end
      end
      ST_INTA2: begin
        if (intal_reg) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETL_0) begin
      req_reg    <= '0;
      pend_reg   <= '0;
      mask_reg   <= '1;
      insv_reg   <= '0;
      rotate_reg <= 1'b0;
      base_reg   <= '0;
      ptr_reg    <= '0;
      state_reg  <= ST_IDLE;
      win_reg    <= '0;
      intal_reg  <= 1'b1;
      intl_reg   <= 1'b1;
      voe_reg    <= 1'b0;
      vec_reg    <= '0;
    end else begin
      req_reg   <= bus.REQ;
      intal_reg <= bus.INTAL;
      pend_reg  <= (pend_reg & ~pend_clr) | req_rise;
      insv_reg  <= (insv_reg & ~insv_clr) | insv_set;
      if (bus.MASKW) mask_reg <= bus.WD[NSRC-1:0];
      if (bus.MODEW) begin
        rotate_reg <= bus.WD[0];
        base_reg   <= bus.WD[7:3];
      end
      if (!rotate_reg)
        ptr_reg <= '0;
      else if (eoi)
        ptr_reg <= next_ptr(insv_idx, NSRC);
      state_reg <= state_next;
      win_reg   <= win_next;
      intl_reg  <= !((state_next == ST_ASSERT) || (state_next == ST_INTA1));
      voe_reg   <= (state_next == ST_INTA2);
      if (vec_load) vec_reg <= {base_reg, win_next};
    end
  end

  assign bus.INTL = intl_reg;
  assign bus.VOE  = voe_reg;
  assign bus.VEC  = vec_reg;
  assign bus.PEND = pend_reg;
  assign bus.INSV = insv_reg;

endmodule
